// File: rtl/reset_release_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// reset_release_sequencer
//
// Produces the per-domain resets consumed by async-reset flops. The outputs
// assert asynchronously as soon as `async` rises. They deassert only on `clk`
// edges: first a synchroniser chain clears, then a hold period runs, and then
// the bits release one at a time, bit 0 first. `done` is raised once every bit
// is low.
//
// Ports:
//   clk         in   1        rising-edge clock
//   async       in   1        asynchronous active-high reset (also resets this block)
//   sw_rst_req  in   1        synchronous software reset request, active-high
//   rst_out     out  NUM_OUT  per-domain resets, active-high, bit 0 releases first
//   done        out  1        high once every rst_out bit is released
//   busy        out  1        high while the FSM is not in DONE
//   sw_evt_cnt  out  8        saturating count of accepted sw_rst_req rising
//                             edges (only when RST_SEQ_EVENT_CNT_EN is defined)
//
// Optional feature macro: RST_SEQ_EVENT_CNT_EN
//
// Parameters:
//   SYNC_STAGES  depth of the deassertion synchroniser (>= 2)
//   HOLD_CYCLES  extra cycles held after the chain clears (>= 0)
//   STAGGER      cycles between successive bit releases (>= 1)
//   NUM_OUT      number of reset domains (>= 1)
// ----------------------------------------------------------------------------
module reset_release_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 4,
   parameter int STAGGER     = 2,
   parameter int NUM_OUT     = 3
) (
   input  logic               clk,
   input  logic               async,
   input  logic               sw_rst_req,
   output logic [NUM_OUT-1:0] rst_out,
   output logic               done,
   output logic               busy
`ifdef RST_SEQ_EVENT_CNT_EN
   ,
   output logic [7:0]         sw_evt_cnt
`endif
);

   localparam int MAX_CNT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
   localparam int CW      = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);
   localparam int IW      = (NUM_OUT < 1) ? 1 : $clog2(NUM_OUT + 1);

   localparam logic [CW-1:0]      HOLD_CNT  = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0]      STAG_LAST = CW'(STAGGER - 1);
   localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_OUT);
   localparam logic [NUM_OUT-1:0] ONE       = NUM_OUT'(1);

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                 w_sync_out;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [IW-1:0]        r_idx;
   logic [IW-1:0]        w_idx_nxt;
   logic [NUM_OUT-1:0]   r_rst;
   logic [NUM_OUT-1:0]   w_rst_nxt;
   logic                 w_sw_accept;

   // Deassertion synchroniser: set by async, shifts zeros in from stage 0.
   always_ff @(posedge clk or posedge async) begin
      if (async) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
      end
   end

   assign w_sync_out  = r_sync[SYNC_STAGES-1];
   assign w_sw_accept = sw_rst_req && (r_state != ST_SYNC);

   always_ff @(posedge clk or posedge async) begin
      if (async) begin
         r_state <= ST_SYNC;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_rst   <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_rst   <= w_rst_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_rst_nxt   = r_rst;

      case (r_state)
         ST_SYNC, ST_HOLD: begin
            // The edge that first sees the chain low is treated as hold
            // count 0, so the SYNC exit and a software-entered HOLD share
            // the same counting rule.
            if ((r_state == ST_HOLD) || !w_sync_out) begin
               if (r_cnt == HOLD_CNT) begin
                  w_rst_nxt   = r_rst & ~ONE;
                  w_idx_nxt   = IW'(1);
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_RELEASE;
               end else begin
                  w_cnt_nxt   = r_cnt + CW'(1);
                  w_state_nxt = ST_HOLD;
               end
            end
         end
         ST_RELEASE: begin
            if (r_idx == LAST_IDX) begin
               w_state_nxt = ST_DONE;
            end else if (r_cnt == STAG_LAST) begin
               w_rst_nxt = r_rst & ~(ONE << r_idx);
               w_idx_nxt = r_idx + IW'(1);
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_DONE;
         end
         default: begin
            w_state_nxt = ST_SYNC;
         end
      endcase

      // Software reset overrides the sequence but leaves the chain alone.
      if (w_sw_accept) begin
         w_rst_nxt   = '1;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
         w_state_nxt = ST_HOLD;
      end
   end

   // OR with async so the outputs assert even before the flops react.
   assign rst_out = r_rst | {NUM_OUT{async}};
   assign done    = (r_state == ST_DONE);
   assign busy    = (r_state != ST_DONE);

`ifdef RST_SEQ_EVENT_CNT_EN
   logic       r_sw_prev;
   logic [7:0] r_evt_cnt;

   always_ff @(posedge clk or posedge async) begin
      if (async) begin
         r_sw_prev <= 1'b0;
         r_evt_cnt <= 8'h00;
      end else begin
         r_sw_prev <= sw_rst_req;
         if (w_sw_accept && !r_sw_prev && (r_evt_cnt != 8'hFF)) begin
            r_evt_cnt <= r_evt_cnt + 8'd1;
         end
      end
   end

   assign sw_evt_cnt = r_evt_cnt;
`endif

endmodule

// File: tb/tb_reset_release_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_reset_release_sequencer
//
// Directed bench for reset_release_sequencer. u_dut uses the default
// parameters; u_dut_b uses SYNC_STAGES=3, HOLD_CYCLES=0, STAGGER=1,
// NUM_OUT=1. Edges are numbered from the first rising edge after the
// reset source drops.
// ----------------------------------------------------------------------------
module tb_reset_release_sequencer;

   logic       clk    = 1'b0;
   logic       clk_en = 1'b1;
   logic       async  = 1'b1;
   logic       sw     = 1'b0;
   logic [2:0] rst_out;
   logic       done;
   logic       busy;

   logic       async_b = 1'b1;
   logic       sw_b    = 1'b0;
   logic [0:0] rst_out_b;
   logic       done_b;
   logic       busy_b;

`ifdef RST_SEQ_EVENT_CNT_EN
   logic [7:0] evt;
   logic [7:0] evt_b;
`endif

   int n_vec    = 0;
   int n_miscmp = 0;

   // ---------------- clock ----------------
   // Clock stops (holding its level) while clk_en is low.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // ---------------- DUTs ----------------
   reset_release_sequencer #(
      .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGGER(2), .NUM_OUT(3)
   ) u_dut (
      .clk(clk),
      .async(async),
      .sw_rst_req(sw),
      .rst_out(rst_out),
      .done(done),
      .busy(busy)
`ifdef RST_SEQ_EVENT_CNT_EN
      ,
      .sw_evt_cnt(evt)
`endif
   );

   reset_release_sequencer #(
      .SYNC_STAGES(3), .HOLD_CYCLES(0), .STAGGER(1), .NUM_OUT(1)
   ) u_dut_b (
      .clk(clk),
      .async(async_b),
      .sw_rst_req(sw_b),
      .rst_out(rst_out_b),
      .done(done_b),
      .busy(busy_b)
`ifdef RST_SEQ_EVENT_CNT_EN
      ,
      .sw_evt_cnt(evt_b)
`endif
   );

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Hand-derived release table for the default instance: bit 0 falls at
   // edge `first`, bit 1 two edges later, bit 2 two edges after that.
   function automatic logic [2:0] exp_rst(input int k, input int first);
      if (k < first)          return 3'b111;
      else if (k < first + 2) return 3'b110;
      else if (k < first + 4) return 3'b100;
      else                    return 3'b000;
   endfunction

   // Checks edges 1..last_edge; done/busy flip one edge after the last bit.
   task automatic run_seq(input string tag, input int first, input int last_edge);
      for (int k = 1; k <= last_edge; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s_rst_e%0d", tag, k), 32'(rst_out), 32'(exp_rst(k, first)));
         chk($sformatf("%s_done_e%0d", tag, k), 32'(done), 32'(k >= first + 5));
         chk($sformatf("%s_busy_e%0d", tag, k), 32'(busy), 32'(k < first + 5));
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      // Power-on: reset held for 10 ns, released mid low phase.
      #2;
      chk("por_rst_reset", 32'(rst_out), 32'h7);
      chk("por_done_reset", 32'(done), 32'h0);
      chk("por_busy_reset", 32'(busy), 32'h1);
`ifdef RST_SEQ_EVENT_CNT_EN
      chk("por_evt_reset", 32'(evt), 32'h0);
`endif
      #10 async = 1'b0;
      run_seq("por", 7, 12);

      // Async pulse with the clock stopped low.
      @(negedge clk);
      clk_en = 1'b0;
      #3 async = 1'b1;
      #1;
      chk("noclk_rst_pulse", 32'(rst_out), 32'h7);
      chk("noclk_done_pulse", 32'(done), 32'h0);
      chk("noclk_busy_pulse", 32'(busy), 32'h1);
      #1 async = 1'b0;
      #3;
      chk("noclk_rst_after", 32'(rst_out), 32'h7);
      clk_en = 1'b1;
      run_seq("noclk", 7, 12);

      // Mid-release async: fresh sequence, abort right after edge 9.
      @(negedge clk);
      #1 async = 1'b1;
      @(negedge clk);
      #2 async = 1'b0;
      run_seq("mid_a", 7, 9);
      async = 1'b1;
      #1;
      chk("mid_rst_abort", 32'(rst_out), 32'h7);
      chk("mid_done_abort", 32'(done), 32'h0);
      chk("mid_busy_abort", 32'(busy), 32'h1);
      @(negedge clk);
      #2 async = 1'b0;
      run_seq("mid_b", 7, 12);

      // Software reset from DONE, high for three edges.
      @(negedge clk);
      sw = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         #1;
         chk($sformatf("sw_rst_hold%0d", j), 32'(rst_out), 32'h7);
         chk($sformatf("sw_done_hold%0d", j), 32'(done), 32'h0);
         chk($sformatf("sw_busy_hold%0d", j), 32'(busy), 32'h1);
      end
      sw = 1'b0;
      run_seq("sw", 5, 10);

`ifdef RST_SEQ_EVENT_CNT_EN
      chk("evt_after_sw", 32'(evt), 32'h1);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         sw = 1'b1;
         @(negedge clk);
         sw = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("evt_saturate", 32'(evt), 32'hFF);
      @(negedge clk);
      #1 async = 1'b1;
      #2 async = 1'b0;
      #1;
      chk("evt_async_clear", 32'(evt), 32'h0);
      chk("evt_rst_async", 32'(rst_out), 32'h7);
`endif

      // Boundary instance; sw_rst_req held high through the SYNC edges.
      @(negedge clk);
      #2;
      async_b = 1'b0;
      sw_b    = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bnd_rst_e%0d", k), 32'(rst_out_b), 32'(k < 4));
         chk($sformatf("bnd_done_e%0d", k), 32'(done_b), 32'(k >= 5));
         chk($sformatf("bnd_busy_e%0d", k), 32'(busy_b), 32'(k < 5));
         if (k == 3) sw_b = 1'b0;
      end
`ifdef RST_SEQ_EVENT_CNT_EN
      chk("bnd_evt_sync_ignored", 32'(evt_b), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
